// File: rtl/mem_line_arbiter_if.sv
// Requester and memory-side signal bundle for the line arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_line_arbiter_if #(parameter int ADDR_W = 32);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [127:0]      d_wdata;
    logic              d_done;
    logic [127:0]      line_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic              mem_we;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;
    logic              busy;
    logic              grant_d;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output i_done, d_done, line_out, mem_addr, mem_rden, mem_we, mem_din, busy, grant_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  i_done, d_done, line_out, mem_addr, mem_rden, mem_we, mem_din, busy, grant_d
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Arbitrated 4-word burst engine sharing one memory port between the I-cache
// refill path and the D-cache refill/writeback path.
module mem_line_arbiter #(
    parameter int ADDR_W     = 32,
    parameter bit D_PRIORITY = 1'b0
) (
    input logic             clk,
    input logic             RESET,
    mem_line_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_TAIL = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [ADDR_W-5:0]  base_q, base_d;
    logic               src_is_d_q, src_is_d_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0][31:0]   wdata_q, wdata_d;
    logic [3:0][31:0]   line_q, line_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rden_q, mem_rden_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_din_q, mem_din_d;
    logic               busy_q, busy_d;
    logic               grant_d_q, grant_d_d;
    logic               pick_d;
    logic               unused_addr_lsbs;

    // D wins a tie under fixed priority, or when I held the previous grant
    assign pick_d = bus.d_req & (~bus.i_req | D_PRIORITY | ~last_grant_q);
    assign unused_addr_lsbs = ^{bus.i_addr[3:0], bus.d_addr[3:0]};

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        src_is_d_d   = src_is_d_q;
        last_grant_d = last_grant_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    src_is_d_d   = pick_d;
                    last_grant_d = pick_d;
                    cnt_d        = 2'd0;
                    if (pick_d) begin
                        base_d = bus.d_addr[ADDR_W-1:4];
                    end else begin
                        base_d = bus.i_addr[ADDR_W-1:4];
                    end
                    if (pick_d && bus.d_we) begin
                        wdata_d = bus.d_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                // Read data trails the address by one cycle, so word cnt-1 lands now
                if (cnt_q != 2'd0) begin
                    line_d[~(cnt_q - 2'd1)] = bus.mem_dout;
                end else begin
                    line_d = line_q;
                end
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd3) ? S_RD_TAIL : S_RD;
            end
            S_RD_TAIL: begin
                line_d[0] = bus.mem_dout;
                state_d   = S_DONE;
            end
            S_WR: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd3) ? S_DONE : S_WR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered
        mem_rden_d = (state_d == S_RD);
        mem_we_d   = (state_d == S_WR);
        mem_addr_d = (mem_rden_d || mem_we_d) ? {base_d, cnt_d, 2'b00} : '0;
        mem_din_d  = mem_we_d ? wdata_d[~cnt_d] : 32'h0;
        i_done_d   = (state_d == S_DONE) && !src_is_d_d;
        d_done_d   = (state_d == S_DONE) && src_is_d_d;
        busy_d     = (state_d != S_IDLE);
        grant_d_d  = busy_d && src_is_d_d;
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            base_q       <= '0;
            src_is_d_q   <= 1'b0;
            last_grant_q <= 1'b0;
            wdata_q      <= '0;
            line_q       <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_rden_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= 32'h0;
            busy_q       <= 1'b0;
            grant_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            src_is_d_q   <= src_is_d_d;
            last_grant_q <= last_grant_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_rden_q   <= mem_rden_d;
            mem_we_q     <= mem_we_d;
            mem_din_q    <= mem_din_d;
            busy_q       <= busy_d;
            grant_d_q    <= grant_d_d;
        end
    end

    assign bus.i_done   = i_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.line_out = line_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rden = mem_rden_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.busy     = busy_q;
    assign bus.grant_d  = grant_d_q;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: round-robin instance with a word memory,
// plus a fixed-priority instance used for grant-order checks.
module tb_mem_line_arbiter;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    typedef struct packed {
        logic         is_d;
        logic         grant;
        logic [127:0] line;
        int           cyc;
    } done_t;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mem_line_arbiter_if #(.ADDR_W(32)) bus0 ();
    mem_line_arbiter_if #(.ADDR_W(32)) bus1 ();

    mem_line_arbiter #(.ADDR_W(32), .D_PRIORITY(1'b0)) dut0 (.clk(clk), .RESET(RESET), .bus(bus0));
    mem_line_arbiter #(.ADDR_W(32), .D_PRIORITY(1'b1)) dut1 (.clk(clk), .RESET(RESET), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit [31:0] mem_x [0:4095];
    bit [31:0] ref_x [0:4095];
    mem_op_t   obs_mem[$];
    done_t     obs_done[$];
    mem_op_t   exp_mem[$];
    done_t     exp_done[$];
    logic      grants1[$];
    logic      busy1_prev;
    int        both_hi = 0;

    function automatic logic [31:0] pat(input logic [11:0] i);
        return {20'hC0DE0, i};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_x[a[13:2]] ^ pat(a[13:2]);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] b);
        return {ref_rd(b), ref_rd(b + 32'd4), ref_rd(b + 32'd8), ref_rd(b + 32'd12)};
    endfunction

    // Word memory for the round-robin instance; contents are stored xor a per-address pattern
    always @(posedge clk) begin
        if (bus0.mem_rden) bus0.mem_dout <= mem_x[bus0.mem_addr[13:2]] ^ pat(bus0.mem_addr[13:2]);
        if (bus0.mem_we) mem_x[bus0.mem_addr[13:2]] <= bus0.mem_din ^ pat(bus0.mem_addr[13:2]);
    end
    assign bus1.mem_dout = 32'h0;

    // Observation recorder for memory accesses and done pulses
    always @(negedge clk) begin
        if (!RESET) begin
            if (bus0.mem_rden || bus0.mem_we)
                obs_mem.push_back('{we: bus0.mem_we, addr: bus0.mem_addr, data: bus0.mem_din});
            if (bus0.mem_rden && bus0.mem_we) both_hi <= both_hi + 1;
            if (bus0.i_done || bus0.d_done)
                obs_done.push_back('{is_d: bus0.d_done && !bus0.i_done, grant: bus0.grant_d,
                                     line: bus0.line_out, cyc: cyc});
        end
    end

    // Grant-side recorder for the fixed-priority instance
    always @(negedge clk) begin
        if (RESET) begin
            busy1_prev <= 1'b0;
        end else begin
            busy1_prev <= bus1.busy;
            if (bus1.busy && !busy1_prev) grants1.push_back(bus1.grant_d);
        end
    end

    task automatic push_ops(input logic we, input logic [31:0] base, input logic [127:0] wd);
        logic [3:0][31:0] w;
        w = wd;
        for (int j = 0; j < 4; j++)
            exp_mem.push_back('{we: we, addr: base + 32'(4 * j), data: we ? w[3 - j] : 32'h0});
    endtask

    task automatic run_txn(input logic use_i, input logic use_d, input logic dwe,
                           input logic [31:0] ia, input logic [31:0] da, input logic [127:0] wd,
                           input int drop_i_after, output logic tmo, output int t0);
        logic pend_i, pend_d;
        int k;
        @(negedge clk);
        bus0.i_addr = ia; bus0.d_addr = da; bus0.d_we = dwe; bus0.d_wdata = wd;
        bus0.i_req = use_i; bus0.d_req = use_d;
        pend_i = use_i; pend_d = use_d; t0 = cyc; tmo = 1'b0; k = 0;
        while ((pend_i || pend_d) && !tmo) begin
            @(negedge clk);
            k++;
            if (bus0.i_done) begin pend_i = 1'b0; bus0.i_req = 1'b0; end
            if (bus0.d_done) begin pend_d = 1'b0; bus0.d_req = 1'b0; end
            if (drop_i_after > 0 && k == drop_i_after) bus0.i_req = 1'b0;
            if (k > 60) tmo = 1'b1;
        end
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.busy, bus0.i_done, bus0.d_done, bus0.mem_rden, bus0.mem_we, bus0.grant_d} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000",
                {bus0.busy, bus0.i_done, bus0.d_done, bus0.mem_rden, bus0.mem_we, bus0.grant_d});
        end
        checks++;
        if (bus0.line_out !== 128'h0) begin failures++; $display("FAIL reset_line: got %h expected 0", bus0.line_out); end
        checks++;
        if ({bus0.mem_addr, bus0.mem_din} !== 64'h0) begin
            failures++; $display("FAIL reset_addr_din: got %h %h expected 0 0", bus0.mem_addr, bus0.mem_din);
        end
        checks++;
        if ({bus1.busy, bus1.grant_d} !== 2'b0) begin failures++; $display("FAIL reset_dut1: got %b expected 00", {bus1.busy, bus1.grant_d}); end
        RESET = 1'b0;
    endtask

    task automatic test_i_read();
        logic tmo; int t0; int mi; int di; mem_op_t o; done_t d, e;
        mi = obs_mem.size(); di = obs_done.size();
        push_ops(1'b0, 32'h1230, 128'h0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h1238, 32'h0, 128'h0, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b0, grant: 1'b0, line: ref_line(32'h1230), cyc: t0 + 6});
        checks++; if (tmo) begin failures++; $display("FAIL i_read_timeout: got 1 expected 0"); end
        while (exp_mem.size() > 0) begin
            o = (mi < obs_mem.size()) ? obs_mem[mi] : '1; mi++;
            checks++; if (o !== exp_mem[0]) begin failures++; $display("FAIL i_read_op: got %h expected %h", o, exp_mem[0]); end
            void'(exp_mem.pop_front());
        end
        while (exp_done.size() > 0) begin
            d = (di < obs_done.size()) ? obs_done[di] : '0; di++; e = exp_done.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL i_read_done: got %h expected %h", d, e); end
        end
        checks++; if (obs_done.size() != di) begin failures++; $display("FAIL i_read_extra_done: got %0d expected %0d", obs_done.size(), di); end
    endtask

    task automatic test_d_write();
        logic tmo; int t0; int mi; int di; mem_op_t o; done_t d, e;
        logic [127:0] prev;
        mi = obs_mem.size(); di = obs_done.size();
        prev = ref_line(32'h1230);
        push_ops(1'b1, 32'h40, {32'd1, 32'd2, 32'd3, 32'd4});
        for (int j = 0; j < 4; j++) ref_x[16 + j] = 32'(j + 1) ^ pat(12'(16 + j));
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h47, {32'd1, 32'd2, 32'd3, 32'd4}, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b1, grant: 1'b1, line: prev, cyc: t0 + 5});
        push_ops(1'b0, 32'h40, 128'h0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h4C, 128'h0, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b1, grant: 1'b1, line: ref_line(32'h40), cyc: t0 + 6});
        checks++; if (tmo) begin failures++; $display("FAIL d_write_timeout: got 1 expected 0"); end
        while (exp_mem.size() > 0) begin
            o = (mi < obs_mem.size()) ? obs_mem[mi] : '1; mi++;
            checks++; if (o !== exp_mem[0]) begin failures++; $display("FAIL d_write_op: got %h expected %h", o, exp_mem[0]); end
            void'(exp_mem.pop_front());
        end
        while (exp_done.size() > 0) begin
            d = (di < obs_done.size()) ? obs_done[di] : '0; di++; e = exp_done.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL d_write_done: got %h expected %h", d, e); end
        end
        checks++; if (both_hi != 0) begin failures++; $display("FAIL rden_we_overlap: got %0d expected 0", both_hi); end
    endtask

    task automatic test_tie_rr();
        logic tmo; int t0; int mi; int di; done_t d, e;
        @(negedge clk); RESET = 1'b1; @(negedge clk); RESET = 1'b0;
        mi = obs_mem.size(); di = obs_done.size();
        run_txn(1'b1, 1'b1, 1'b0, 32'h1230, 32'h40, 128'h0, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b1, grant: 1'b1, line: ref_line(32'h40), cyc: t0 + 6});
        exp_done.push_back('{is_d: 1'b0, grant: 1'b0, line: ref_line(32'h1230), cyc: t0 + 13});
        // A lone D write leaves last_grant on D, so the next tie goes to I
        for (int j = 0; j < 4; j++) ref_x[32 + j] = 32'(j + 5) ^ pat(12'(32 + j));
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h80, {32'd5, 32'd6, 32'd7, 32'd8}, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b1, grant: 1'b1, line: ref_line(32'h1230), cyc: t0 + 5});
        run_txn(1'b1, 1'b1, 1'b0, 32'h1230, 32'h80, 128'h0, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b0, grant: 1'b0, line: ref_line(32'h1230), cyc: t0 + 6});
        exp_done.push_back('{is_d: 1'b1, grant: 1'b1, line: ref_line(32'h80), cyc: t0 + 13});
        checks++; if (tmo) begin failures++; $display("FAIL tie_timeout: got 1 expected 0"); end
        while (exp_done.size() > 0) begin
            d = (di < obs_done.size()) ? obs_done[di] : '0; di++; e = exp_done.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL tie_done: got %h expected %h", d, e); end
        end
        checks++; if (obs_mem.size() - mi != 20) begin failures++; $display("FAIL tie_op_count: got %0d expected 20", obs_mem.size() - mi); end
    endtask

    task automatic test_prio();
        int nd; int gi; logic done_i; logic exp_g[$];
        gi = grants1.size(); nd = 0; done_i = 1'b0;
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        bus1.i_addr = 32'h100; bus1.d_addr = 32'h200; bus1.d_we = 1'b0; bus1.d_wdata = 128'h0;
        bus1.i_req = 1'b1; bus1.d_req = 1'b1;
        for (int k = 0; k < 120 && !done_i; k++) begin
            @(negedge clk);
            if (bus1.d_done) begin nd++; if (nd == 3) bus1.d_req = 1'b0; end
            if (bus1.i_done) begin done_i = 1'b1; bus1.i_req = 1'b0; end
        end
        bus1.i_req = 1'b0; bus1.d_req = 1'b0;
        #1;
        checks++; if (!done_i) begin failures++; $display("FAIL prio_timeout: got 0 expected 1"); end
        checks++; if (grants1.size() - gi != 4) begin failures++; $display("FAIL prio_count: got %0d expected 4", grants1.size() - gi); end
        for (int j = 0; j < 4 && gi + j < grants1.size(); j++) begin
            checks++;
            if (grants1[gi + j] !== exp_g[j]) begin failures++; $display("FAIL prio_grant[%0d]: got %b expected %b", j, grants1[gi + j], exp_g[j]); end
        end
    endtask

    task automatic test_reset_mid();
        logic tmo; int t0; int di; int mi; mem_op_t o; done_t d, e;
        @(negedge clk);
        bus0.i_addr = 32'h1230; bus0.i_req = 1'b1;
        repeat (3) @(negedge clk);
        #1; RESET = 1'b1; bus0.i_req = 1'b0;
        #1;
        checks++;
        if ({bus0.busy, bus0.mem_rden, bus0.mem_addr, bus0.line_out} !== 162'h0) begin
            failures++; $display("FAIL reset_mid_outputs: got %b %b %h %h expected all 0",
                bus0.busy, bus0.mem_rden, bus0.mem_addr, bus0.line_out);
        end
        di = obs_done.size();
        @(negedge clk); RESET = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (obs_done.size() != di) begin failures++; $display("FAIL reset_mid_no_done: got %0d expected %0d", obs_done.size(), di); end
        mi = obs_mem.size();
        push_ops(1'b0, 32'h1230, 128'h0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h1230, 32'h0, 128'h0, 0, tmo, t0);
        exp_done.push_back('{is_d: 1'b0, grant: 1'b0, line: ref_line(32'h1230), cyc: t0 + 6});
        checks++; if (tmo) begin failures++; $display("FAIL reset_mid_timeout: got 1 expected 0"); end
        while (exp_mem.size() > 0) begin
            o = (mi < obs_mem.size()) ? obs_mem[mi] : '1; mi++;
            checks++; if (o !== exp_mem[0]) begin failures++; $display("FAIL reset_mid_op: got %h expected %h", o, exp_mem[0]); end
            void'(exp_mem.pop_front());
        end
        while (exp_done.size() > 0) begin
            d = (di < obs_done.size()) ? obs_done[di] : '0; di++; e = exp_done.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL reset_mid_done: got %h expected %h", d, e); end
        end
    endtask

    task automatic test_drop_mid();
        logic tmo; int t0; int mi; int di; done_t d, e;
        mi = obs_mem.size(); di = obs_done.size();
        run_txn(1'b1, 1'b0, 1'b0, 32'h1244, 32'h0, 128'h0, 2, tmo, t0);
        exp_done.push_back('{is_d: 1'b0, grant: 1'b0, line: ref_line(32'h1240), cyc: t0 + 6});
        repeat (6) @(negedge clk);
        #1;
        checks++; if (tmo) begin failures++; $display("FAIL drop_timeout: got 1 expected 0"); end
        while (exp_done.size() > 0) begin
            d = (di < obs_done.size()) ? obs_done[di] : '0; di++; e = exp_done.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL drop_done: got %h expected %h", d, e); end
        end
        checks++; if (obs_done.size() != di) begin failures++; $display("FAIL drop_regrant_done: got %0d expected %0d", obs_done.size(), di); end
        checks++; if (obs_mem.size() - mi != 4) begin failures++; $display("FAIL drop_op_count: got %0d expected 4", obs_mem.size() - mi); end
        checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL drop_idle: got %b expected 0", bus0.busy); end
    endtask

    initial begin
        bus0.i_req = 1'b0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.i_addr = 32'h0; bus0.d_addr = 32'h0; bus0.d_wdata = 128'h0;
        bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.i_addr = 32'h0; bus1.d_addr = 32'h0; bus1.d_wdata = 128'h0;
        test_reset();
        test_i_read();
        test_d_write();
        test_tie_rr();
        test_prio();
        test_reset_mid();
        test_drop_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Sequences line-granular (4-word, 128-bit) transfers between the single shared Memory port and two requesters: the L1 instruction-cache refill path and the L1 data-cache refill/writeback path.
- Replaces the per-cache fsm_control/cacheReg/wordChunk address sequencing with one arbitrated burst engine.
- Grants one requester at a time, issues four word accesses and assembles or streams the line. Signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, byte-address width of requester and memory addresses.
- D_PRIORITY, 0, 0 = round-robin between I and D on simultaneous requests; 1 = D-side always wins.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache line refill request (level, held until i_done)
- i_addr  in  ADDR_W  I-side address; bits [3:0] ignored
- i_done  out  1  one-cycle pulse: I-side line valid on line_out
- d_req  in  1  D-cache line request (level, held until d_done)
- d_we  in  1  1 = writeback of d_wdata, 0 = refill
- d_addr  in  ADDR_W  D-side address; bits [3:0] ignored
- d_wdata  in  128  writeback line; word0 in [127:96]
- d_done  out  1  one-cycle pulse: D-side transfer complete (line_out valid if refill)
- line_out  out  128  assembled read line; word0 in [127:96], word3 in [31:0]
- mem_addr  out  ADDR_W  word address to Memory
- mem_rden  out  1  Memory read enable
- mem_we  out  1  Memory write enable (size fixed to word)
- mem_din  out  32  Memory write data
- mem_dout  in  32  Memory read data, valid one cycle after mem_rden
- busy  out  1  high in any state other than IDLE
- grant_d  out  1  1 while the current transfer belongs to the D-side

Behaviour:
- Reset (async, any state): state = IDLE, cnt = 0, line_out = 0, all outputs 0, last_grant = I (D wins the first tie). A burst interrupted by reset is abandoned; no done pulse is issued.
- States: IDLE, RD, RD_TAIL, WR, DONE. cnt is a 2-bit word index.
- IDLE:
  - Samples the requests. If only one is high, that side wins.
  - If both are high: D wins when D_PRIORITY = 1. Otherwise the side that was not last_grant wins.
  - On a grant: latch the line base {addr[ADDR_W-1:4], 4'b0}, latch the source and direction, latch d_wdata if writing, update last_grant, set cnt = 0.
  - Next state: WR for a D-side write, RD otherwise. I-side is always a read; there is no I-side write.
- RD (4 cycles):
  - Each cycle: mem_rden = 1, mem_addr = base + 4*cnt, cnt increments.
  - From the second RD cycle on, capture mem_dout into line_out word (cnt-1).
  - After cnt = 3 go to RD_TAIL.
- RD_TAIL (1 cycle): mem_rden = 0, capture mem_dout into word 3, go to DONE.
- WR (4 cycles):
  - Each cycle: mem_we = 1, mem_addr = base + 4*cnt, mem_din = latched word cnt, cnt increments.
  - After cnt = 3 go to DONE.
- DONE (1 cycle): pulse i_done or d_done per the latched source; line_out is stable. Next state: IDLE.
- Latency from grant cycle to done pulse: 6 cycles for a read, 5 cycles for a write.
- line_out holds its value until the next read burst begins capturing; write bursts never modify it.
- Request inputs are ignored outside IDLE. Deasserting a request mid-burst does not abort; done is still pulsed.
- Requesters must drop req no later than the cycle after done, or they are re-granted.
- mem_rden and mem_we are never both high. mem_addr and mem_din are 0 when neither is asserted.
- Address wrap: base + 4*cnt only changes bits [3:2]; no carry into bit 4.

Test Plan:
- Reset, then i_req = 1, i_addr = 0x0000_1238 with memory words 0x1230..0x123C = A,B,C,D -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C with mem_rden; i_done pulses 6 cycles after grant; line_out = {A,B,C,D}; d_done stays 0.
- d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = {1,2,3,4} -> four writes to 0x40..0x4C with data 1..4; d_done pulses on cycle 5; line_out unchanged; a readback refill returns {1,2,3,4}.
- i_req and d_req rise in the same cycle after reset, both held until serviced (D_PRIORITY = 0) -> D served first, then I. A repeat of the simultaneous request yields alternation I, then D.
- D_PRIORITY = 1, both requests held continuously -> D is granted every time; I is granted only when d_req is low in IDLE.
- Assert RESET during the third RD cycle -> outputs go to 0 immediately, no done pulse; a new i_req afterwards completes normally with correct data.
- i_req dropped in the second RD cycle -> burst completes and i_done still pulses; arbiter returns to IDLE with no re-grant.
